// File: rtl/usb_clk_pkg.sv
// Shared types and default constants for the USB clock/reset sequencer.
// Holds the sequencer FSM encoding and the counter-width helper.
package usb_clk_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      RUN       = 2'd2
   } seq_state_e;

   localparam int USB_FS_DIV        = 8;
   localparam int USB_LS_DIV        = 64;
   localparam int USB_STABLE_CYCLES = 1024;
   localparam int USB_STAB_W        = $clog2(USB_STABLE_CYCLES);
   localparam int USB_DIV_W         = $clog2(USB_LS_DIV);

   // A counter always needs at least one bit, even when it only ever holds 0.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/usb_clk_rst_seq_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by rstn.
// Used to bring the PLL lock flag into the pll96 domain.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/usb_clk_rst_seq.sv
// PLL-lock driven reset sequencer with full/low-speed USB clock enables.
// Optional lock-loss counter enabled by defining USB_CLK_RST_SEQ_LOSS_CNT_EN.
module usb_clk_rst_seq
   import usb_clk_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = USB_STABLE_CYCLES,
   parameter int FS_DIV        = USB_FS_DIV,
   parameter int LS_DIV        = USB_LS_DIV
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       locked,
   output logic       usb_rst,
   output logic       ready,
   output logic       ce_fs,
   output logic       ce_ls,
   output logic [7:0] lock_loss_cnt
);

   localparam int STAB_W = cnt_w(STABLE_CYCLES);
   localparam int DIV_W  = cnt_w(LS_DIV);

   logic              lock_s;
   seq_state_e        state_q, state_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              usb_rst_q, usb_rst_d;
   logic              ready_q, ready_d;
   logic              ce_fs_q, ce_fs_d;
   logic              ce_ls_q, ce_ls_d;

   sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk  (clk),
      .rstn (rstn),
      .d_i  (locked),
      .q_o  (lock_s)
   );

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d = state_q;
      stab_d  = stab_q;
      div_d   = '0;
      ce_fs_d = 1'b0;
      ce_ls_d = 1'b0;
      unique case (state_q)
         WAIT_LOCK: begin
            stab_d = '0;
            if (lock_s) state_d = STABILIZE;
         end
         STABILIZE: begin
            // A dropout on the terminal cycle still forces a full restart.
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               stab_d  = '0;
            end else if (stab_q == STAB_W'(STABLE_CYCLES - 1)) begin
               state_d = RUN;
               stab_d  = '0;
            end else begin
               stab_d = stab_q + STAB_W'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else begin
               div_d   = (div_q == DIV_W'(LS_DIV - 1)) ? '0 : div_q + DIV_W'(1);
               ce_fs_d = (int'(div_q) % FS_DIV) == (FS_DIV - 1);
               ce_ls_d = (div_q == DIV_W'(LS_DIV - 1));
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
      usb_rst_d = (state_d != RUN);
      ready_d   = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= WAIT_LOCK;
         stab_q    <= '0;
         div_q     <= '0;
         usb_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         ce_fs_q   <= 1'b0;
         ce_ls_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         stab_q    <= stab_d;
         div_q     <= div_d;
         usb_rst_q <= usb_rst_d;
         ready_q   <= ready_d;
         ce_fs_q   <= ce_fs_d;
         ce_ls_q   <= ce_ls_d;
      end
   end

`ifdef USB_CLK_RST_SEQ_LOSS_CNT_EN
   logic [7:0] loss_q;

   // Saturating count of RUN exits; only rstn clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         loss_q <= 8'd0;
      end else if (state_q == RUN && state_d == WAIT_LOCK && loss_q != 8'hFF) begin
         loss_q <= loss_q + 8'd1;
      end
   end

   assign lock_loss_cnt = loss_q;
`else
   assign lock_loss_cnt = 8'd0;
`endif

   assign usb_rst = usb_rst_q;
   assign ready   = ready_q;
   assign ce_fs   = ce_fs_q;
   assign ce_ls   = ce_ls_q;

endmodule

// File: tb/tb_usb_clk_rst_seq.sv
// Self-checking bench for usb_clk_rst_seq: vector table, corner sequences and random lock traffic
// checked every cycle against a window-based model of the release and strobe rules.
module tb_usb_clk_rst_seq;

   localparam int SYNC = 2;
   localparam int STAB = 16;
   localparam int FS   = 8;
   localparam int LS   = 64;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       locked = 1'b1;
   logic       usb_rst, ready, ce_fs, ce_ls;
   logic [7:0] lock_loss_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   usb_clk_rst_seq #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STAB),
      .FS_DIV        (FS),
      .LS_DIV        (LS)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .locked        (locked),
      .usb_rst       (usb_rst),
      .ready         (ready),
      .ce_fs         (ce_fs),
      .ce_ls         (ce_ls),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: ready after edge n iff the locked samples taken at edges
   // n-SYNC-STAB .. n-SYNC were all 1; strobes are multiples of FS/LS edges past release.
   int     n_m = 0;
   int     rel_m = 0;
   int     loss_m = 0;
   bit     ready_m = 0;
   bit     samp[$];
   bit     ready_new, fs_m, ls_m;

   always @(posedge clk) begin
      if (!rstn) begin
         n_m = 0;
         samp.delete();
         ready_m = 0;
         rel_m = 0;
         loss_m = 0;
      end else begin
         n_m++;
         samp.push_back(locked);
         ready_new = (n_m >= SYNC + STAB + 1);
         if (ready_new)
            for (int k = n_m - SYNC - STAB; k <= n_m - SYNC; k++)
               if (!samp[k-1]) ready_new = 0;
`ifdef USB_CLK_RST_SEQ_LOSS_CNT_EN
         if (ready_m && !ready_new && loss_m < 255) loss_m++;
`endif
         if (!ready_m && ready_new) rel_m = n_m;
         ready_m = ready_new;
      end
      fs_m = ready_m && (n_m > rel_m) && ((n_m - rel_m) % FS == 0);
      ls_m = ready_m && (n_m > rel_m) && ((n_m - rel_m) % LS == 0);
      #1;
      check("mdl_usb_rst", usb_rst, !ready_m);
      check("mdl_ready", ready, ready_m);
      check("mdl_ce_fs", ce_fs, fs_m);
      check("mdl_ce_ls", ce_ls, ls_m);
      check("mdl_loss_cnt", lock_loss_cnt, loss_m);
   end

   typedef struct {
      logic  rstn;
      logic  locked;
      int    cycles;
      logic  exp_rst;
      logic  exp_ready;
      logic  exp_fs;
      logic  exp_ls;
      string name;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int cnt;
      int hi, lo;
      logic [7:0] exp_loss;

      vecs[0]  = '{1'b0, 1'b1,  3, 1'b1, 1'b0, 1'b0, 1'b0, "reset"};
      vecs[1]  = '{1'b1, 1'b1, 18, 1'b1, 1'b0, 1'b0, 1'b0, "pre_release"};
      vecs[2]  = '{1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, "release_19"};
      vecs[3]  = '{1'b1, 1'b1,  7, 1'b0, 1'b1, 1'b0, 1'b0, "no_fs_yet"};
      vecs[4]  = '{1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b1, 1'b0, "first_fs"};
      vecs[5]  = '{1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, "fs_gap"};
      vecs[6]  = '{1'b1, 1'b1,  7, 1'b0, 1'b1, 1'b1, 1'b0, "second_fs"};
      vecs[7]  = '{1'b1, 1'b1, 47, 1'b0, 1'b1, 1'b0, 1'b0, "pre_ls"};
      vecs[8]  = '{1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b1, 1'b1, "first_ls"};
      vecs[9]  = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, "loss_edge1"};
      vecs[10] = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, "loss_edge2"};
      vecs[11] = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0, "loss_edge3"};
      vecs[12] = '{1'b1, 1'b1, 18, 1'b1, 1'b0, 1'b0, 1'b0, "relock_pre"};
      vecs[13] = '{1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, "relock_19"};
      vecs[14] = '{1'b0, 1'b1,  0, 1'b1, 1'b0, 1'b0, 1'b0, "async_rst"};
      vecs[15] = '{1'b0, 1'b1,  2, 1'b1, 1'b0, 1'b0, 1'b0, "hold_rst"};

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rstn   = vecs[i].rstn;
         locked = vecs[i].locked;
         repeat (vecs[i].cycles) @(posedge clk);
         #2;
         check({vecs[i].name, "_usb_rst"}, usb_rst, vecs[i].exp_rst);
         check({vecs[i].name, "_ready"}, ready, vecs[i].exp_ready);
         check({vecs[i].name, "_ce_fs"}, ce_fs, vecs[i].exp_fs);
         check({vecs[i].name, "_ce_ls"}, ce_ls, vecs[i].exp_ls);
         if (!vecs[i].rstn) check({vecs[i].name, "_loss_cnt"}, lock_loss_cnt, 0);
      end

      // Unstable lock: 10 good samples, a single dropout, then release 19 edges after the re-rise.
      @(negedge clk);
      rstn = 1'b1;
      locked = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk) locked = 1'b0;
      @(posedge clk);
      @(negedge clk) locked = 1'b1;
      cnt = 0;
      while (usb_rst && cnt < 60) begin
         @(posedge clk);
         #1 cnt++;
      end
      check("unstable_relock_latency", cnt, 19);

      // Dropout seen by the FSM exactly on the stabilize terminal cycle: restart wins.
      @(negedge clk) rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      locked = 1'b1;
      repeat (16) @(posedge clk);
      @(negedge clk) locked = 1'b0;
      @(posedge clk);
      @(negedge clk) locked = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("race_ready", ready, 0);
      check("race_usb_rst", usb_rst, 1);
      cnt = 0;
      while (usb_rst && cnt < 60) begin
         @(posedge clk);
         #1 cnt++;
      end
      check("race_relock_latency", cnt, 17);

      // Random lock traffic with occasional resets, checked by the model every cycle.
      for (int i = 0; i < 60; i++) begin
         hi = $urandom_range(5, 100);
         lo = $urandom_range(1, 5);
         @(negedge clk) locked = 1'b1;
         repeat (hi) @(negedge clk);
         locked = 1'b0;
         if ($urandom_range(0, 9) == 0) rstn = 1'b0;
         repeat (lo) @(negedge clk);
         rstn = 1'b1;
      end

      // Many RUN exits to drive the loss counter into saturation.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk) locked = 1'b1;
         cnt = 0;
         while (!ready && cnt < 40) begin
            @(posedge clk);
            #1 cnt++;
         end
         check("loss_phase_release", ready, 1);
         @(negedge clk) locked = 1'b0;
         repeat (3) @(negedge clk);
      end
`ifdef USB_CLK_RST_SEQ_LOSS_CNT_EN
      exp_loss = 8'd255;
`else
      exp_loss = 8'd0;
`endif
      check("loss_cnt_final", lock_loss_cnt, exp_loss);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
